// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze/flush sequencer for the 5-stage pipeline; counters enabled by PIPE_CTRL_PERF_EN
module pipe_hazard_ctrl #(
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_in,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_freeze,
  output logic             idex_flush,
  output logic             exmem_freeze,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, BR_FLUSH = 2'd2;
  localparam logic [3:0] BR_LOAD = 4'(BRANCH_PENALTY - 1);
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);
  localparam bit BR_MULTI = BRANCH_PENALTY > 1;
  logic [1:0] state_q, state_d;
  logic [3:0] br_cnt_q, br_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic mem_timeout_q, mem_timeout_d;
  logic mem_stall, br_go, hz_go;
  always_comb begin
    mem_stall = mem_access & ~mem_ready;
    br_go = branch_taken & ~mem_stall;
    hz_go = hazard_in & ~mem_stall & ~branch_taken & (state_q != BR_FLUSH);
    state_d = state_q;
    br_cnt_d = br_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
        else if (br_go && BR_MULTI) begin
          state_d = BR_FLUSH;
          br_cnt_d = BR_LOAD;
        end
      end
      MEM_WAIT: state_d = mem_stall ? MEM_WAIT : RUN;
      BR_FLUSH: begin
        // a memory stall pauses the flush window; a new branch restarts it
        if (br_go) br_cnt_d = BR_LOAD;
        else if (!mem_stall) begin
          br_cnt_d = br_cnt_q - 4'd1;
          if (br_cnt_q <= 4'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    wait_cnt_d = mem_stall ? ((&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 16'd1) : 16'd0;
    mem_timeout_d = mem_timeout_q | (mem_stall & (wait_cnt_q == TO_LAST));
    pc_freeze = ~rst & (mem_stall | hz_go);
    ifid_freeze = ~rst & (mem_stall | hz_go);
    ifid_flush = ~rst & ~mem_stall & (branch_taken | (state_q == BR_FLUSH));
    idex_freeze = ~rst & mem_stall;
    idex_flush = ~rst & (br_go | hz_go);
    exmem_freeze = ~rst & mem_stall;
    memwb_flush = ~rst & mem_stall;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      br_cnt_q <= '0;
      wait_cnt_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      br_cnt_q <= br_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
  assign state = state_q;
  assign mem_timeout = mem_timeout_q;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  always_comb begin
    stall_cycles_d = stall_cycles_q + CNT_W'(mem_stall & ~&stall_cycles_q);
    flush_events_d = flush_events_q + CNT_W'(br_go & ~&flush_events_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table plus scoreboard bench for pipe_hazard_ctrl (BRANCH_PENALTY=3, MEM_TIMEOUT=8)
module tb_pipe_hazard_ctrl;
  localparam logic [6:0] Z = 7'b0000000, FZ = 7'b1101011, BR = 7'b0010100, HZ = 7'b1100100, BF = 7'b0010000;
  typedef struct {
    logic r, h, b, a, y;
    logic [6:0] ctl;
    logic [1:0] st;
    logic to;
    logic [15:0] sc, fe;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, hazard_in = 1'b0, branch_taken = 1'b0, mem_access = 1'b0, mem_ready = 1'b0;
  logic pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush, exmem_freeze, memwb_flush, mem_timeout;
  logic [1:0] state;
  logic [15:0] stall_cycles, flush_events;
  vec_t tbl[$];
  vec_t sb[$];
  int n_vec = 0, n_bad = 0;
  pipe_hazard_ctrl #(.BRANCH_PENALTY(3), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hazard_in(hazard_in), .branch_taken(branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready), .pc_freeze(pc_freeze),
    .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush), .idex_freeze(idex_freeze),
    .idex_flush(idex_flush), .exmem_freeze(exmem_freeze), .memwb_flush(memwb_flush),
    .mem_timeout(mem_timeout), .state(state), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] pc(input int x);
`ifdef PIPE_CTRL_PERF_EN
    return 16'(x);
`else
    return 16'(x * 0);
`endif
  endfunction
  function automatic vec_t mk(input logic r, h, b, a, y, input logic [6:0] ctl, input int st, input logic to, input int sc, fe);
    vec_t v;
    v.r = r; v.h = h; v.b = b; v.a = a; v.y = y;
    v.ctl = ctl; v.st = 2'(st); v.to = to; v.sc = pc(sc); v.fe = pc(fe);
    return v;
  endfunction
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.r; hazard_in = v.h; branch_taken = v.b; mem_access = v.a; mem_ready = v.y;
    sb.push_back(v);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      logic [41:0] act, exp;
      e = sb.pop_front();
      act = {pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush, exmem_freeze, memwb_flush,
             state, mem_timeout, stall_cycles, flush_events};
      exp = {e.ctl, e.st, e.to, e.sc, e.fe};
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec%0d ctl/st/to/sc/fe got %b/%0d/%b/%0d/%0d want %b/%0d/%b/%0d/%0d", n_vec,
                 act[41:35], act[34:33], act[32], act[31:16], act[15:0], e.ctl, e.st, e.to, e.sc, e.fe);
      end
      n_vec++;
    end
  end
  initial begin
    tbl.push_back(mk(1,0,0,0,0, Z, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, Z, 0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, HZ,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, Z, 0,0, 0,0));
    tbl.push_back(mk(0,0,1,0,0, BR,0,0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, BF,2,0, 0,1));
    tbl.push_back(mk(0,1,0,0,0, BF,2,0, 0,1));
    tbl.push_back(mk(0,0,0,0,0, Z, 0,0, 0,1));
    tbl.push_back(mk(0,0,1,1,0, FZ,0,0, 0,1));
    tbl.push_back(mk(0,0,1,1,0, FZ,1,0, 1,1));
    tbl.push_back(mk(0,0,1,1,0, FZ,1,0, 2,1));
    tbl.push_back(mk(0,0,1,1,0, FZ,1,0, 3,1));
    tbl.push_back(mk(0,0,1,1,1, BR,1,0, 4,1));
    tbl.push_back(mk(0,0,0,0,0, Z, 0,0, 4,2));
    for (int k = 1; k <= 10; k++) tbl.push_back(mk(0,0,0,1,0, FZ, (k == 1) ? 0 : 1, k > 8, 3 + k, 2));
    tbl.push_back(mk(0,0,0,1,1, Z, 1,1,14,2));
    tbl.push_back(mk(0,0,0,0,0, Z, 0,1,14,2));
    tbl.push_back(mk(0,1,0,1,0, FZ,0,1,14,2));
    tbl.push_back(mk(0,1,0,0,0, HZ,1,1,15,2));
    tbl.push_back(mk(0,0,1,0,0, BR,0,1,15,2));
    tbl.push_back(mk(0,0,0,1,0, FZ,2,1,15,3));
    tbl.push_back(mk(0,0,0,0,0, BF,2,1,16,3));
    tbl.push_back(mk(0,0,1,0,0, BR,2,1,16,3));
    tbl.push_back(mk(0,0,0,0,0, BF,2,1,16,4));
    tbl.push_back(mk(0,0,0,0,0, BF,2,1,16,4));
    tbl.push_back(mk(0,0,0,0,0, Z, 0,1,16,4));
    foreach (tbl[i]) apply(tbl[i]);
    // reset mid-wait: watchdog must restart from zero afterwards
    for (int k = 1; k <= 5; k++) apply(mk(0,0,0,1,0, FZ, (k == 1) ? 0 : 1, 1, 15 + k, 4));
    apply(mk(1,0,0,1,0, Z, 0,0, 0,0));
    for (int k = 1; k <= 9; k++) apply(mk(0,0,0,1,0, FZ, (k == 1) ? 0 : 1, k > 8, k - 1, 0));
    apply(mk(0,0,0,0,0, Z, 1,1, 9,0));
    apply(mk(0,0,0,0,0, Z, 0,1, 9,0));
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
